// File: rtl/stark_imul_sched.sv
`default_nettype none
// stark_imul_sched: round-robin issue scheduler for a shared fixed-latency multiplier,
// with a LAT-deep shadow pipeline and a credit-protected, stomp-aware result FIFO.
module stark_imul_sched #(
  parameter int WID    = 64,
  parameter int NREQ   = 4,
  parameter int LAT    = 3,
  parameter int FDEPTH = 4,
  parameter int RW     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2**RW-1:0]        stomp,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*RW-1:0]      req_rndx_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic                    mul_valid_o,
  output logic [$clog2(NREQ)-1:0] mul_sel_o,
  input  logic [WID-1:0]          mul_res_i,
  output logic                    wb_valid_o,
  output logic [WID-1:0]          wb_data_o,
  output logic [RW-1:0]           wb_rndx_o,
  input  logic                    wb_ready_i,
  output logic                    busy_o
);
  localparam int SW = $clog2(NREQ);
  localparam int PW = $clog2(FDEPTH);
  localparam int CW = $clog2(FDEPTH + 1);
  localparam int IW = $clog2(LAT + 1);

  logic [SW-1:0]  rr_ptr;
  logic [LAT-1:0] sh_valid;
  logic [LAT-1:0] sh_used;
  logic [RW-1:0]  sh_rndx [LAT];
  logic [LAT-1:0] sh_live;

  logic [WID-1:0]    f_data [FDEPTH];
  logic [RW-1:0]     f_rndx [FDEPTH];
  logic [FDEPTH-1:0] f_kill;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     fifo_cnt;
  logic [IW-1:0]     inflight_cnt;
  logic [WID-1:0]    last_data;
  logic [RW-1:0]     last_rndx;

  logic [NREQ-1:0] elig;
  logic            credit;
  logic            issue;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   arb_idx;
  logic [NREQ-1:0] gnt;
  logic [RW-1:0]   iss_rndx;
  logic            capture;
  logic            nonempty;
  logic            head_dead;
  logic            pop;

  always_comb begin
    elig = '0;
    for (int k = 0; k < NREQ; k++)
      elig[k] = req_i[k] & ~stomp[req_rndx_i[k*RW +: RW]];
  end

  // Slots stay consumed until they exit the shadow pipe, killed or not.
  always_comb begin
    inflight_cnt = '0;
    for (int s = 0; s < LAT; s++)
      inflight_cnt = inflight_cnt + IW'(sh_used[s]);
  end

  assign credit = (int'(fifo_cnt) + int'(inflight_cnt)) < FDEPTH;

  always_comb begin
    gnt     = '0;
    sel     = '0;
    issue   = 1'b0;
    arb_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      arb_idx = rr_ptr + SW'(i);
      if (!issue && !rst && credit && elig[arb_idx]) begin
        issue = 1'b1;
        sel   = arb_idx;
      end
    end
    if (issue)
      gnt[sel] = 1'b1;
  end

  always_comb begin
    iss_rndx = '0;
    for (int k = 0; k < NREQ; k++)
      if (SW'(k) == sel)
        iss_rndx = req_rndx_i[k*RW +: RW];
  end

  assign gnt_o       = gnt;
  assign mul_valid_o = issue;
  assign mul_sel_o   = sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (issue)
      rr_ptr <= sel + SW'(1);
  end

  always_comb begin
    sh_live = '0;
    for (int s = 0; s < LAT; s++)
      sh_live[s] = sh_valid[s] & ~stomp[sh_rndx[s]];
  end

  assign capture = sh_live[LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_valid <= '0;
      sh_used  <= '0;
      for (int s = 0; s < LAT; s++)
        sh_rndx[s] <= '0;
    end else begin
      sh_valid[0] <= issue;
      sh_used[0]  <= issue;
      sh_rndx[0]  <= iss_rndx;
      for (int s = 1; s < LAT; s++) begin
        sh_valid[s] <= sh_live[s-1];
        sh_used[s]  <= sh_used[s-1];
        sh_rndx[s]  <= sh_rndx[s-1];
      end
    end
  end

  assign nonempty   = fifo_cnt != '0;
  assign head_dead  = nonempty & (f_kill[rd_ptr] | stomp[f_rndx[rd_ptr]]);
  assign wb_valid_o = nonempty & ~head_dead;
  assign pop        = head_dead | (wb_valid_o & wb_ready_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < FDEPTH; e++) begin
        f_data[e] <= '0;
        f_rndx[e] <= '0;
      end
      f_kill    <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      fifo_cnt  <= '0;
      last_data <= '0;
      last_rndx <= '0;
    end else begin
      for (int e = 0; e < FDEPTH; e++)
        if (stomp[f_rndx[e]])
          f_kill[e] <= 1'b1;
      // A capture is never stomped in its own cycle, so it enters un-killed.
      if (capture) begin
        f_data[wr_ptr] <= mul_res_i;
        f_rndx[wr_ptr] <= sh_rndx[LAT-1];
        f_kill[wr_ptr] <= 1'b0;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (capture && !pop)
        fifo_cnt <= fifo_cnt + CW'(1);
      else if (!capture && pop)
        fifo_cnt <= fifo_cnt - CW'(1);
      if (nonempty) begin
        last_data <= f_data[rd_ptr];
        last_rndx <= f_rndx[rd_ptr];
      end
    end
  end

  assign wb_data_o = nonempty ? f_data[rd_ptr] : last_data;
  assign wb_rndx_o = nonempty ? f_rndx[rd_ptr] : last_rndx;
  assign busy_o    = nonempty | (inflight_cnt != '0);

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(capture && fifo_cnt == CW'(FDEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_stark_imul_sched.sv
`default_nettype none
// tb_stark_imul_sched: directed self-checking bench with a writeback scoreboard.
module tb_stark_imul_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stomp;
  logic [3:0]  req;
  logic [4:0]  r [4];
  logic [19:0] rndx;
  logic [3:0]  gnt;
  logic        mul_valid;
  logic [1:0]  mul_sel;
  logic [63:0] mul_res;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_rndx;
  logic        wb_ready;
  logic        busy;

  int unsigned cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int n_wb  = 0;

  typedef struct {
    logic [4:0]  rndx;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  assign rndx    = {r[3], r[2], r[1], r[0]};
  assign mul_res = {32'hC0DE0000, cyc};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stark_imul_sched dut (
    .clk(clk), .rst(rst), .stomp(stomp), .req_i(req), .req_rndx_i(rndx),
    .gnt_o(gnt), .mul_valid_o(mul_valid), .mul_sel_o(mul_sel), .mul_res_i(mul_res),
    .wb_valid_o(wb_valid), .wb_data_o(wb_data), .wb_rndx_o(wb_rndx),
    .wb_ready_i(wb_ready), .busy_o(busy)
  );

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample once per cycle: record issues, score accepted writebacks.
  task automatic settle();
    exp_t e;
    #1;
    if (mul_valid) begin
      e.rndx = r[mul_sel];
      e.data = {32'hC0DE0000, cyc + 32'd3};
      exp_q.push_back(e);
    end
    if (wb_valid && wb_ready) begin
      n_wb++;
      if (exp_q.size() == 0)
        check("wb_unexpected", 64'(wb_valid), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("wb_rndx", 64'(wb_rndx), 64'(e.rndx));
        check("wb_data", wb_data, e.data);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  task automatic purge(input logic [4:0] b);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].rndx == b)
        exp_q.delete(i);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ng, next, nres, base;
    rst = 1'b1; stomp = '0; req = '0; wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) r[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, with requests present to show grants are held off.
    req = 4'hF;
    #1;
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_mul_valid", 64'(mul_valid), 64'(0));
    check("rst_mul_sel", 64'(mul_sel), 64'(0));
    check("rst_wb_valid", 64'(wb_valid), 64'(0));
    check("rst_wb_data", wb_data, 64'(0));
    check("rst_wb_rndx", 64'(wb_rndx), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    req = '0;
    rst = 1'b0;
    adv();

    // Single issue from requester 2, result appears LAT+1 cycles later.
    r[2] = 5'd7; req = 4'b0100; wb_ready = 1'b1;
    settle();
    check("t1_gnt", 64'(gnt), 64'(4'b0100));
    check("t1_mul_valid", 64'(mul_valid), 64'(1));
    check("t1_mul_sel", 64'(mul_sel), 64'(2));
    adv();
    req = '0;
    for (int i = 1; i <= 5; i++) begin
      settle();
      check("t1_wb_valid", 64'(wb_valid), 64'(i == 4));
      if (i == 4) check("t1_wb_rndx", 64'(wb_rndx), 64'(7));
      adv();
    end
    settle();
    check("t1_busy", 64'(busy), 64'(0));
    adv();

    // All requesting: round-robin from pointer 3, credit-limited to 13 of 16 cycles.
    r[0] = 5'd10; r[1] = 5'd11; r[2] = 5'd12; r[3] = 5'd13;
    req = 4'hF; next = 3; ng = 0;
    for (int c = 0; c < 16; c++) begin
      settle();
      if (mul_valid) begin
        check("t2_gnt_order", 64'(gnt), 64'(1 << next));
        next = (next + 1) % 4;
        ng++;
      end
      adv();
    end
    req = '0;
    check("t2_grants", 64'(ng), 64'(13));
    repeat (8) step();
    settle();
    check("t2_busy", 64'(busy), 64'(0));
    check("t2_pending", 64'(exp_q.size()), 64'(0));
    adv();

    // Backpressure: exactly FDEPTH issues, then drain and resume.
    r[0] = 5'd20; req = 4'b0001; wb_ready = 1'b0; ng = 0;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (gnt[0]) ng++;
      adv();
    end
    check("t3_grants", 64'(ng), 64'(4));
    settle();
    check("t3_gnt_stalled", 64'(gnt), 64'(0));
    check("t3_wb_valid", 64'(wb_valid), 64'(1));
    check("t3_wb_rndx", 64'(wb_rndx), 64'(20));
    check("t3_busy", 64'(busy), 64'(1));
    adv();
    wb_ready = 1'b1; nres = 0;
    for (int c = 0; c < 8; c++) begin
      settle();
      if (c == 0) check("t3_pop_no_credit", 64'(gnt), 64'(0));
      if (c == 1) check("t3_resume_gnt", 64'(gnt), 64'(1));
      if (mul_valid) nres++;
      adv();
    end
    check("t3_resumed", 64'(nres > 0), 64'(1));
    req = '0;
    repeat (10) step();
    settle();
    check("t3_busy_end", 64'(busy), 64'(0));
    check("t3_pending", 64'(exp_q.size()), 64'(0));
    adv();

    // In-flight stomp of rndx 4 between 3 and 5.
    req = 4'b0001; wb_ready = 1'b1;
    r[0] = 5'd3; settle(); check("t4_issue3", 64'(mul_valid), 64'(1)); adv();
    r[0] = 5'd4; settle(); check("t4_issue4", 64'(mul_valid), 64'(1)); adv();
    r[0] = 5'd5; settle(); check("t4_issue5", 64'(mul_valid), 64'(1)); adv();
    req = '0;
    stomp[4] = 1'b1; purge(5'd4);
    step();
    stomp = '0;
    base = n_wb;
    repeat (8) step();
    check("t4_wb_count", 64'(n_wb - base), 64'(2));
    settle();
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_pending", 64'(exp_q.size()), 64'(0));
    adv();

    // Buffered head stomped: auto-pop without writeback.
    wb_ready = 1'b0; req = 4'b0001;
    r[0] = 5'd9;  step();
    r[0] = 5'd10; step();
    req = '0;
    repeat (5) step();
    settle();
    check("t5_head_valid", 64'(wb_valid), 64'(1));
    check("t5_head_rndx", 64'(wb_rndx), 64'(9));
    adv();
    stomp[9] = 1'b1; purge(5'd9);
    settle();
    check("t5_stomp_blocks", 64'(wb_valid), 64'(0));
    adv();
    stomp = '0;
    settle();
    check("t5_next_valid", 64'(wb_valid), 64'(1));
    check("t5_next_rndx", 64'(wb_rndx), 64'(10));
    adv();
    wb_ready = 1'b1;
    repeat (3) step();
    settle();
    check("t5_pending", 64'(exp_q.size()), 64'(0));
    adv();

    // Reset with 2 in flight and 2 buffered discards everything.
    wb_ready = 1'b1; req = 4'b0001; r[0] = 5'd21;
    step(); step();
    req = '0; wb_ready = 1'b0;
    repeat (4) step();
    r[0] = 5'd22; req = 4'b0001;
    step(); step();
    req = '0;
    rst = 1'b1;
    #1;
    check("t6_gnt", 64'(gnt), 64'(0));
    check("t6_wb_valid", 64'(wb_valid), 64'(0));
    check("t6_wb_data", wb_data, 64'(0));
    check("t6_wb_rndx", 64'(wb_rndx), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    exp_q.delete();
    adv();
    rst = 1'b0; wb_ready = 1'b1;
    base = n_wb;
    repeat (8) step();
    check("t6_no_stale_wb", 64'(n_wb - base), 64'(0));
    settle();
    check("t6_busy_end", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
